// File: rtl/id_ex_stage_reg_if.sv
// ID/EX boundary bundle: decoder-side capture inputs, EX-side registered
// outputs, hazard controls and the halt-drain status.
interface id_ex_stage_reg_if #(
    parameter int DATA_W = 32
);
    logic              stall;
    logic              flush;
    logic              regwrite_d, memwrite_d, alusrc_d;
    logic              branch_d, jump_d, jumpr_d;
    logic [1:0]        memtoreg_d, regdst_d, pcsel_d;
    logic [2:0]        alu_op_d;
    logic              load_d;
    logic [5:0]        funct_d;
    logic [4:0]        rs_d, rt_d, rd_d;
    logic [DATA_W-1:0] rd1_d, rd2_d, signimm_d, pcplus4_d;

    logic              regwrite_e, memwrite_e, alusrc_e;
    logic              branch_e, jump_e, jumpr_e;
    logic [1:0]        memtoreg_e, regdst_e, pcsel_e;
    logic [2:0]        alu_op_e;
    logic              load_e;
    logic [5:0]        funct_e;
    logic [4:0]        rs_e, rt_e, rd_e;
    logic [DATA_W-1:0] rd1_e, rd2_e, signimm_e, pcplus4_e;
    logic              drain_busy;
    logic              halted;

    modport master (
        output stall, flush,
        output regwrite_d, memwrite_d, alusrc_d,
        output branch_d, jump_d, jumpr_d,
        output memtoreg_d, regdst_d, pcsel_d,
        output alu_op_d, load_d, funct_d,
        output rs_d, rt_d, rd_d,
        output rd1_d, rd2_d, signimm_d, pcplus4_d,
        input  regwrite_e, memwrite_e, alusrc_e,
        input  branch_e, jump_e, jumpr_e,
        input  memtoreg_e, regdst_e, pcsel_e,
        input  alu_op_e, load_e, funct_e,
        input  rs_e, rt_e, rd_e,
        input  rd1_e, rd2_e, signimm_e, pcplus4_e,
        input  drain_busy, halted
    );

    modport slave (
        input  stall, flush,
        input  regwrite_d, memwrite_d, alusrc_d,
        input  branch_d, jump_d, jumpr_d,
        input  memtoreg_d, regdst_d, pcsel_d,
        input  alu_op_d, load_d, funct_d,
        input  rs_d, rt_d, rd_d,
        input  rd1_d, rd2_d, signimm_d, pcplus4_d,
        output regwrite_e, memwrite_e, alusrc_e,
        output branch_e, jump_e, jumpr_e,
        output memtoreg_e, regdst_e, pcsel_e,
        output alu_op_e, load_e, funct_e,
        output rs_e, rt_e, rd_e,
        output rd1_e, rd2_e, signimm_e, pcplus4_e,
        output drain_busy, halted
    );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with stall hold, flush bubbles and a HALT
// drain sequencer that waits for MEM and WB to empty before halting.
module id_ex_stage_reg #(
    parameter int DATA_W       = 32,
    parameter int DRAIN_CYCLES = 2
) (
    input logic               clk,
    input logic               rst,
    id_ex_stage_reg_if.slave  bus
);
    localparam int CW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CW-1:0] DRAIN_INIT = CW'(DRAIN_CYCLES);

    typedef struct packed {
        logic              regwrite, memwrite, alusrc;
        logic              branch, jump, jumpr;
        logic [1:0]        memtoreg, regdst, pcsel;
        logic [2:0]        alu_op;
        logic              load;
        logic [5:0]        funct;
        logic [4:0]        rs, rt, rd;
        logic [DATA_W-1:0] rd1, rd2, signimm, pcplus4;
    } stage_t;

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic           busy_q;
    logic           halted_q;
    stage_t         q;
    stage_t         d;
    stage_t         bubble;

    always_comb begin
        bubble      = '0;
        bubble.load = 1'b1;
    end

    always_comb begin
        d = '{
            regwrite: bus.regwrite_d, memwrite: bus.memwrite_d,
            alusrc:   bus.alusrc_d,   branch:   bus.branch_d,
            jump:     bus.jump_d,     jumpr:    bus.jumpr_d,
            memtoreg: bus.memtoreg_d, regdst:   bus.regdst_d,
            pcsel:    bus.pcsel_d,    alu_op:   bus.alu_op_d,
            load:     bus.load_d,     funct:    bus.funct_d,
            rs:       bus.rs_d,       rt:       bus.rt_d,
            rd:       bus.rd_d,       rd1:      bus.rd1_d,
            rd2:      bus.rd2_d,      signimm:  bus.signimm_d,
            pcplus4:  bus.pcplus4_d
        };
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q        <= bubble;
            state    <= RUN;
            cnt      <= '0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (bus.flush) begin
                        q <= bubble;
                    end else if (!bus.stall) begin
                        q <= d;
                        // A captured HALT occupies EX and starts the drain
                        if (!d.load) begin
                            state  <= DRAIN;
                            cnt    <= DRAIN_INIT;
                            busy_q <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    q <= bubble;
                    if (cnt <= CW'(1)) begin
                        cnt      <= '0;
                        state    <= HALTED;
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HALTED: begin
                    q <= bubble;
                end
                default: begin
                    q     <= bubble;
                    state <= RUN;
                end
            endcase
        end
    end

    assign bus.regwrite_e = q.regwrite;
    assign bus.memwrite_e = q.memwrite;
    assign bus.alusrc_e   = q.alusrc;
    assign bus.branch_e   = q.branch;
    assign bus.jump_e     = q.jump;
    assign bus.jumpr_e    = q.jumpr;
    assign bus.memtoreg_e = q.memtoreg;
    assign bus.regdst_e   = q.regdst;
    assign bus.pcsel_e    = q.pcsel;
    assign bus.alu_op_e   = q.alu_op;
    assign bus.load_e     = q.load;
    assign bus.funct_e    = q.funct;
    assign bus.rs_e       = q.rs;
    assign bus.rt_e       = q.rt;
    assign bus.rd_e       = q.rd;
    assign bus.rd1_e      = q.rd1;
    assign bus.rd2_e      = q.rd2;
    assign bus.signimm_e  = q.signimm;
    assign bus.pcplus4_e  = q.pcplus4;
    assign bus.drain_busy = busy_q;
    assign bus.halted     = halted_q;
endmodule

// File: doc/id_ex_stage_reg.md
# id_ex_stage_reg

ID/EX pipeline register for the pipelined MIPS core, sitting directly downstream of the main decoder. It captures the decoder's control bundle, register-file operands and instruction fields at the end of Decode and presents them to Execute. It implements stall (hold), flush (bubble insertion) and a halt-drain sequencer, so a HALT opcode retires cleanly once older instructions have left MEM and WB.

## Interface
Parameters:
- DATA_W, 32, operand and immediate width
- DRAIN_CYCLES, 2, cycles after HALT reaches EX before `halted` asserts (MEM + WB), must be ≥1

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hold current EX contents (load-use hazard)
- flush  in  1  load a bubble into EX (taken branch/jump, or load-use bubble)
- regwrite_d, memwrite_d, alusrc_d, branch_d, jump_d, jumpr_d  in  1 each  decoder control
- memtoreg_d, regdst_d, pcsel_d  in  2 each  decoder control
- alu_op_d  in  3  decoder ALU class
- load_d  in  1  decoder PC-load enable, 0 = HALT
- funct_d  in  6  instruction funct field
- rs_d, rt_d, rd_d  in  5 each  register specifiers
- rd1_d, rd2_d, signimm_d, pcplus4_d  in  DATA_W each  operands, sign-extended immediate, PC+4
- `*_e` outputs  out  same widths  registered copies of every `*_d` input above
- drain_busy  out  1  HALT is in EX or draining
- halted  out  1  all instructions through WB, core stopped

## Operation
- Bubble value: every control output 0, `load_e` 1, all data and specifier outputs 0. A bubble never writes a register or memory.
- Per-cycle update priority, highest first:
  1. `rst`
  2. state DRAIN or HALTED: load a bubble; `stall` and `flush` are ignored.
  3. `flush`: load a bubble. Flush wins over a simultaneous stall.
  4. `stall`: hold all outputs.
  5. Otherwise capture all `*_d` inputs.
- FSM states RUN, DRAIN, HALTED. Reset state is RUN.
  - RUN → DRAIN: on a capture (case 5) with `load_d`=0. `load_e`=0 for that one cycle. Counter is loaded with DRAIN_CYCLES.
  - DRAIN: counter decrements each cycle. At count reaching 0 → HALTED.
  - HALTED: absorbing until `rst`.
- A HALT that is flushed or held by stall in Decode does not start the drain.
- `drain_busy` = 1 while the HALT occupies EX and during DRAIN. `halted` = 1 in HALTED only.
- Counter width is `$clog2(DRAIN_CYCLES+1)`. Counter never wraps; it saturates at 0.

## Timing
- Capture latency is one cycle: `*_d` at edge N appears on `*_e` after edge N.
- Async reset clears the following immediately, without waiting for a clock:
  - all outputs to the bubble value (`load_e`=1)
  - `drain_busy`=0, `halted`=0
  - state RUN, counter 0
- Reset mid-drain or in HALTED returns the block to RUN with a bubble in EX. Normal capture resumes on the first edge after `rst` deasserts.
- HALT captured at edge N:
  - `drain_busy` rises after edge N.
  - EX holds a bubble from edge N+1.
  - `halted` rises after edge N+DRAIN_CYCLES.
  - `drain_busy` falls in the same cycle `halted` rises.
- `stall` holding a HALT already in EX is impossible: the FSM has left RUN, so stall is ignored.
- Outputs are purely registered; there is no combinational path from `*_d` to `*_e`.

## Test plan
- Reset then capture:
  - Stimulus: assert `rst` asynchronously mid-cycle; then drive R-type add (regwrite_d=1, regdst_d=01, alu_op_d=010, rd1_d=0x5, rd2_d=0x7, rd_d=3).
  - Response: during reset, outputs are the bubble with load_e=1. One edge after release, regwrite_e=1, regdst_e=01, alu_op_e=010, rd1_e=0x5, rd2_e=0x7, rd_e=3.
- Stall hold:
  - Stimulus: capture LW (memtoreg_d=01, alusrc_d=1, signimm_d=0x10); then assert stall for 2 cycles while the inputs change to SW.
  - Response: memtoreg_e stays 01 and signimm_e stays 0x10 for both cycles. memwrite_e rises on the first edge after stall drops.
- Flush vs stall:
  - Stimulus: assert flush and stall together with BEQ on the inputs.
  - Response: next outputs are all-zero control with load_e=1; branch_e=0.
- Halt drain with DRAIN_CYCLES=2:
  - Stimulus: capture HALT (load_d=0) at edge N; keep valid R-type on the inputs afterwards.
  - Response:
    - load_e=0 and drain_busy=1 after edge N.
    - Bubbles on all outputs from edge N+1; stall/flush pulses have no effect.
    - halted=1 and drain_busy=0 after edge N+2, holding indefinitely.
- Flushed HALT:
  - Stimulus: load_d=0 together with flush.
  - Response: a bubble is loaded, drain_busy stays 0, FSM stays RUN, and the next instruction captures normally.
- Reset in HALTED:
  - Stimulus: pulse `rst` while halted=1.
  - Response: halted drops immediately, and ADDI (regwrite_d=1, alusrc_d=1) captures on the first edge after release.
